// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions used by the instruction fetch unit: the halt opcode,
// the opcode field position and the fetch FSM state encoding.
package instr_fetch_pkg;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam int         OPC_HI  = 15;
    localparam int         OPC_LO  = 11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_HOLD   = 2'd2,
        S_HALTED = 2'd3
    } fetch_state_t;

    // True when the instruction word carries the halt opcode.
    function automatic logic is_halt(input logic [15:0] word);
        return word[OPC_HI:OPC_LO] == OP_HALT;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one read at a time to instruction memory,
// holds the returned word for the decoder until it is consumed, follows
// branch redirects and stops on a halt instruction.
//
// The read request is issued in the same cycle the FSM decides to enter REQ,
// so imem_rd_en/imem_addr are driven from the next-state logic. With a
// one-cycle memory this gives request -> instr_valid in two cycles and one
// instruction every two cycles when the decoder never stalls.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_valid,
    output logic [15:0]       instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_n;
    logic              drop, drop_n;
    logic [15:0]       instr_q, instr_n;
    logic [ADDR_W-1:0] pc_q, pc_n;
    logic              issue;

    // Next-state, next-PC and request generation for the fetch FSM.
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        drop_n     = drop;
        instr_n    = instr_q;
        pc_n       = pc_q;
        issue      = 1'b0;
        unique case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_n    = S_REQ;
                    fetch_pc_n = RESET_PC;
                    drop_n     = 1'b0;
                    issue      = 1'b1;
                end
            end
            S_REQ: begin
                if (branch_taken) begin
                    fetch_pc_n = branch_target;
                    if (imem_valid) begin
                        // Response arriving with the redirect is discarded;
                        // nothing is outstanding any more, so re-issue now.
                        drop_n = 1'b0;
                        issue  = 1'b1;
                    end else begin
                        // A request is still in flight: swallow its response
                        // before issuing the redirected one.
                        drop_n = 1'b1;
                    end
                end else if (imem_valid) begin
                    if (drop) begin
                        drop_n = 1'b0;
                        issue  = 1'b1;
                    end else begin
                        state_n = S_HOLD;
                        instr_n = imem_rdata;
                        pc_n    = fetch_pc;
                    end
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    // Redirect wins over acceptance, including of a halt.
                    state_n    = S_REQ;
                    fetch_pc_n = branch_target;
                    issue      = 1'b1;
                end else if (instr_ready) begin
                    if (is_halt(instr_q)) begin
                        state_n = S_HALTED;
                    end else begin
                        state_n    = S_REQ;
                        fetch_pc_n = fetch_pc + 1'b1;
                        issue      = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, fetch address, drop flag and the held instruction/PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            drop     <= 1'b0;
            instr_q  <= 16'h0000;
            pc_q     <= RESET_PC;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            drop     <= drop_n;
            instr_q  <= instr_n;
            pc_q     <= pc_n;
        end
    end

    assign imem_rd_en  = issue && !rst;
    assign imem_addr   = fetch_pc_n;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign instr_valid = (state == S_HOLD);
    assign halted      = (state == S_HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a behavioural instruction memory with
// programmable latency, plus a second instance at RESET_PC=16'hFFFF that
// shares the same stimulus to observe address wrap.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst, start, instr_ready, branch_taken;
    logic [15:0] branch_target;
    logic        imem_valid;
    logic [15:0] imem_rdata;

    logic        imem_rd_en, instr_valid, halted;
    logic [15:0] imem_addr, instr, pc;

    logic        u1_imem_rd_en, u1_instr_valid, u1_halted;
    logic [15:0] u1_imem_addr, u1_instr, u1_pc;

    // memory model state
    logic [15:0] mem [0:255];
    int          lat;
    logic        pend;
    int          cnt;
    logic [15:0] paddr;
    logic        mv;
    logic [15:0] md;
    logic        inj_v;
    logic [15:0] inj_d;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    assign imem_valid = mv | inj_v;
    assign imem_rdata = inj_v ? inj_d : md;

    instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) u0 (
        .clk(clk), .rst(rst), .start(start),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .pc(pc), .halted(halted)
    );

    instr_fetch #(.ADDR_W(16), .RESET_PC(16'hFFFF)) u1 (
        .clk(clk), .rst(rst), .start(start),
        .imem_rd_en(u1_imem_rd_en), .imem_addr(u1_imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .instr(u1_instr), .instr_valid(u1_instr_valid), .instr_ready(instr_ready),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .pc(u1_pc), .halted(u1_halted)
    );

    // Memory: capture a request mid-cycle, answer 'lat' cycles later.
    initial begin
        pend = 1'b0; cnt = 0; paddr = '0; mv = 1'b0; md = '0;
        forever begin
            @(negedge clk);
            if (imem_rd_en && !rst) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = imem_addr;
            end
            @(posedge clk);
            #1;
            mv = 1'b0;
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    mv   = 1'b1;
                    md   = mem[paddr[7:0]];
                    pend = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int nreq;
        for (int i = 0; i < 256; i++) mem[i] = 16'h7777;
        mem[8'h00] = 16'h2105;
        mem[8'h01] = 16'h5000;
        mem[8'h02] = 16'h0000;
        mem[8'h40] = 16'h3333;
        mem[8'h41] = 16'h0000;
        mem[8'h10] = 16'h4444;
        rst = 1'b1; start = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0;
        branch_target = '0; inj_v = 1'b0; inj_d = '0; lat = 1;

        // reset
        step; step; #1;
        chk("rst_rd_en", imem_rd_en, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_instr", instr, 16'h0000);
        step; rst = 1'b0; #1;
        chk("idle_rd_en", imem_rd_en, 0);

        // basic sequence, 1-cycle memory, ready high
        step; start = 1'b1; instr_ready = 1'b1; #1;
        chk("start_rd_en", imem_rd_en, 1);
        chk("start_addr", imem_addr, 16'h0000);
        chk("u1_start_rd_en", u1_imem_rd_en, 1);
        chk("u1_start_addr", u1_imem_addr, 16'hFFFF);
        for (int k = 0; k < 3; k++) begin
            step; start = 1'b0; #1;
            chk("req_instr_valid", instr_valid, 0);
            chk("req_rd_en", imem_rd_en, 0);
            step; #1;
            chk("hold_instr_valid", instr_valid, 1);
            chk("hold_pc", pc, k);
            case (k)
                0: chk("hold_instr0", instr, 16'h2105);
                1: chk("hold_instr1", instr, 16'h5000);
                default: chk("hold_instr2", instr, 16'h0000);
            endcase
            if (k < 2) begin
                chk("next_rd_en", imem_rd_en, 1);
                chk("next_addr", imem_addr, k + 1);
            end else begin
                chk("halt_no_rd_en", imem_rd_en, 0);
            end
            if (k == 0) begin
                chk("u1_instr_valid", u1_instr_valid, 1);
                chk("u1_instr", u1_instr, 16'h2105);
                chk("u1_pc", u1_pc, 16'hFFFF);
                chk("u1_wrap_addr", u1_imem_addr, 16'h0000);
            end
        end
        step; #1;
        chk("halted", halted, 1);
        chk("halted_instr_valid", instr_valid, 0);
        chk("u1_halted", u1_halted, 1);
        nreq = 0;
        repeat (4) begin
            step; #1;
            if (imem_rd_en) nreq++;
        end
        chk("halted_no_requests", nreq, 0);

        // restart from HALTED, decoder stalls for 5 cycles
        step; instr_ready = 1'b0; start = 1'b1; #1;
        chk("restart_rd_en", imem_rd_en, 1);
        chk("restart_addr", imem_addr, 16'h0000);
        step; start = 1'b0; #1;
        step; #1;
        chk("stall_instr_valid", instr_valid, 1);
        for (int i = 0; i < 5; i++) begin
            step; start = (i == 2); #1;
            chk("stall_instr", instr, 16'h2105);
            chk("stall_pc", pc, 16'h0000);
            chk("stall_rd_en", imem_rd_en, 0);
        end

        // 3-cycle memory, branch while the request is outstanding
        step; start = 1'b0; lat = 3; instr_ready = 1'b1; #1;
        chk("slow_rd_en", imem_rd_en, 1);
        chk("slow_addr", imem_addr, 16'h0001);
        step; branch_taken = 1'b1; branch_target = 16'h0040; #1;
        chk("br_wait_rd_en", imem_rd_en, 0);
        step; branch_taken = 1'b0; #1;
        chk("br_wait2_rd_en", imem_rd_en, 0);
        chk("br_wait2_valid", instr_valid, 0);
        step; #1;
        chk("drop_instr_valid", instr_valid, 0);
        chk("reissue_rd_en", imem_rd_en, 1);
        chk("reissue_addr", imem_addr, 16'h0040);
        step; lat = 1; #1;
        chk("after_drop_valid", instr_valid, 0);
        step; step; step; #1;
        chk("br_instr", instr, 16'h3333);
        chk("br_pc", pc, 16'h0040);
        chk("br_next_addr", imem_addr, 16'h0041);

        // branch coincident with acceptance of a halt
        step; #1;
        step; branch_taken = 1'b1; branch_target = 16'h0010; #1;
        chk("halt_hold_instr", instr, 16'h0000);
        chk("halt_br_rd_en", imem_rd_en, 1);
        chk("halt_br_addr", imem_addr, 16'h0010);
        step; branch_taken = 1'b0; #1;
        chk("halt_br_not_halted", halted, 0);
        chk("halt_br_valid", instr_valid, 0);
        step; #1;
        step; instr_ready = 1'b0; #1;
        chk("br10_instr", instr, 16'h4444);
        chk("br10_pc", pc, 16'h0010);

        // reset in HOLD, then a late response
        step; rst = 1'b1; #1;
        step; rst = 1'b0; inj_v = 1'b1; inj_d = 16'h1234; #1;
        chk("rst_hold_valid", instr_valid, 0);
        chk("rst_hold_instr", instr, 16'h0000);
        chk("rst_hold_pc", pc, 16'h0000);
        chk("rst_hold_halted", halted, 0);
        chk("rst_hold_rd_en", imem_rd_en, 0);
        step; inj_v = 1'b0; branch_taken = 1'b1; branch_target = 16'h0099; #1;
        chk("late_valid_ignored", instr_valid, 0);
        chk("late_instr", instr, 16'h0000);
        chk("idle_branch_rd_en", imem_rd_en, 0);
        step; branch_taken = 1'b0; #1;
        chk("idle_branch_addr", imem_addr, 16'h0000);
        chk("idle_branch_valid", instr_valid, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 16'h0000, meaning the address of the first instruction fetched after start.
REQ-002 The module SHALL have parameter ADDR_W, default 16, meaning the instruction-memory address width.
REQ-003 The module SHALL have one clock and a synchronous active-high reset: clk input 1, rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins fetching at RESET_PC from IDLE or HALTED.
REQ-006 imem_rd_en  output  1  read request to instruction memory.
REQ-007 imem_addr  output  ADDR_W  address of the requested instruction.
REQ-008 imem_rdata  input  16  instruction word returned.
REQ-009 imem_valid  input  1  imem_rdata is valid; arrives 1 or more cycles after the request.
REQ-010 instr  output  16  instruction presented to the decoder.
REQ-011 instr_valid  output  1  instr holds a valid instruction.
REQ-012 instr_ready  input  1  downstream consumes instr this cycle when instr_valid is also high.
REQ-013 branch_taken  input  1  one-cycle redirect pulse from execute.
REQ-014 branch_target  input  ADDR_W  address for the redirect.
REQ-015 pc  output  ADDR_W  address of the instruction currently on instr.
REQ-016 halted  output  1  high while in HALTED.

Function
REQ-017 The FSM SHALL have four states: IDLE, REQ, HOLD and HALTED.
REQ-018 At most one memory request SHALL be outstanding; imem_rd_en SHALL be a single-cycle pulse issued on entry to REQ.
REQ-019 IDLE SHALL transition to REQ on start, with fetch_pc=RESET_PC.
REQ-020 REQ SHALL transition to HOLD on imem_valid, latching instr=imem_rdata and pc=fetch_pc, and asserting instr_valid the next cycle.
REQ-021 HOLD SHALL keep instr and pc stable until instr_ready && instr_valid.
REQ-022 On acceptance in HOLD, if instr[15:11]==OP_HALT the FSM SHALL go to HALTED; otherwise fetch_pc SHALL increment by 1 and the FSM SHALL go to REQ.
REQ-023 Throughput SHALL be 1 instruction per 2 cycles with 1-cycle memory latency and ready held high; fetch-to-instr_valid latency SHALL be 2 cycles from request.
REQ-024 fetch_pc SHALL wrap from all-ones to 0 without error.
REQ-025 branch_taken in any state except IDLE/HALTED SHALL set fetch_pc=branch_target, drop instr_valid next cycle, and re-enter REQ.
REQ-026 If branch_taken occurs while a request is outstanding, the next imem_valid response SHALL be discarded via a drop flag, and the new request SHALL be issued only after that response arrives.
REQ-027 branch_taken coincident with acceptance of a halt instruction SHALL take priority, so that no halt occurs.
REQ-028 branch_taken and imem_valid in the same cycle SHALL discard the response.
REQ-029 branch_taken in IDLE or HALTED SHALL be ignored.
REQ-030 start outside IDLE/HALTED SHALL be ignored.
REQ-031 start in HALTED SHALL restart at RESET_PC.
REQ-032 halted SHALL be high only in HALTED.
REQ-033 instr_valid SHALL be low in IDLE, REQ and HALTED.

Reset
REQ-034 rst SHALL have priority over all inputs and SHALL set state=IDLE, fetch_pc=RESET_PC, instr=16'h0000, pc=RESET_PC, instr_valid=0, imem_rd_en=0, halted=0, and clear the drop flag.
REQ-035 rst mid-request SHALL forget the outstanding request; a late imem_valid seen in IDLE SHALL be ignored.

Structure
REQ-036 The shared cpu package SHALL hold OP_HALT=5'b00000, the opcode field position [15:11], and the fetch-state enum.
REQ-037 The design SHALL be a single module with no sub-module; the PC register and FSM are in-line.

Verification
REQ-038 Reset, then start, with memory returning 16'h2105@0, 16'h5000@1 and 16'h0000@2, ready=1 and 1-cycle latency: instr sequence 2105/5000/0000 with pc 0/1/2, then halted=1 and no further imem_rd_en.
REQ-039 Hold instr_ready low for 5 cycles: instr and pc stable, no new request issued.
REQ-040 Memory latency of 3 cycles, then branch_taken with target 16'h0040 during the wait: the stale response is dropped, the next request is at 0x0040, and pc=0x0040 when valid.
REQ-041 branch_taken to 0x0010 in the same cycle a halt instruction is accepted: no halt, next fetch at 0x0010.
REQ-042 RESET_PC=16'hFFFF with non-halt instructions: fetch addresses are FFFF then 0000.
REQ-043 rst asserted in HOLD, then a late imem_valid: all outputs at reset values, state IDLE, response ignored.
